// File: rtl/spi_pkg.sv
// SPI target shared definitions.
// Mode/length encodings match the SPI master.
package spi_pkg;

    localparam int MAX_WORD = 32;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    typedef enum logic [1:0] {
        LEN8  = 2'b00,
        LEN16 = 2'b01,
        LEN24 = 2'b10,
        LEN32 = 2'b11
    } word_len_e;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    function automatic logic [5:0] word_bits(input logic [1:0] wl);
        return {1'b0, wl, 3'b000} + 6'd8;
    endfunction

    function automatic logic [MAX_WORD-1:0] word_mask(input logic [1:0] wl);
        logic [MAX_WORD-1:0] m;
        unique case (word_len_e'(wl))
            LEN8:    m = 32'h0000_00FF;
            LEN16:   m = 32'h0000_FFFF;
            LEN24:   m = 32'h00FF_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Parallel-side bundle of the SPI target:
// config, TX holding buffer handshake and RX word.
interface spi_slave_if;
    import spi_pkg::*;

    logic [1:0]          spi_mode_i;
    logic [1:0]          word_len_i;
    logic [MAX_WORD-1:0] tx_data_i;
    logic                tx_load_i;
    logic                tx_ready_o;
    logic [MAX_WORD-1:0] rx_data_o;
    logic                rx_valid_o;
    logic                underrun_o;
    logic                busy_o;

    modport slave (
        input  spi_mode_i, word_len_i,
        input  tx_data_i, tx_load_i,
        output tx_ready_o, rx_data_o,
        output rx_valid_o, underrun_o, busy_o
    );

    modport master (
        output spi_mode_i, word_len_i,
        output tx_data_i, tx_load_i,
        input  tx_ready_o, rx_data_o,
        input  rx_valid_o, underrun_o, busy_o
    );

endinterface

// File: rtl/spi_sync_edge.sv
// N-flop synchroniser with a one-flop delayed copy
// for edge detection.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic GCLK,
    input  logic RST,
    input  logic d_i,
    output logic sync_o,
    output logic edge_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    always_ff @(posedge GCLK) begin
        if (RST) begin
            chain_q <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign edge_o = chain_q[STAGES-1] ^ prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI target: oversampled pins, MSB-first shifting,
// single-entry TX holding buffer and RX word output.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       GCLK,
    input  logic       RST,
    spi_slave_if.slave bus,
    input  logic       SCLK_i,
    input  logic       CS_i,
    input  logic       MOSI_i,
    output logic       MISO_o,
    output logic       MISO_oe_o
);

    logic sclk_s, sclk_edge;
    logic cs_s, cs_edge, cs_fall, cs_rise;
    logic mosi_s;

    logic [SYNC_STAGES-1:0] mosi_q;
    logic [SYNC_STAGES-1:0] flush_q;

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sclk (
        .GCLK   (GCLK),
        .RST    (RST),
        .d_i    (SCLK_i),
        .sync_o (sclk_s),
        .edge_o (sclk_edge)
    );

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_cs (
        .GCLK   (GCLK),
        .RST    (RST),
        .d_i    (CS_i),
        .sync_o (cs_s),
        .edge_o (cs_edge)
    );

    assign cs_fall = cs_edge & ~cs_s;
    assign cs_rise = cs_edge & cs_s;
    assign mosi_s  = mosi_q[SYNC_STAGES-1];

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [1:0]          wl_q, wl_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [MAX_WORD-1:0] tsr_q, tsr_d;
    logic [MAX_WORD-1:0] rsr_q, rsr_d;
    logic [MAX_WORD-1:0] buf_q, buf_d;
    logic [MAX_WORD-1:0] rx_q, rx_d;
    logic                full_q, full_d;
    logic                miso_q, miso_d;
    logic                rxv_q, rxv_d;
    logic                und_q, und_d;
    logic                reload_q, reload_d;
    logic                first_q, first_d;
    logic                arm_q, arm_d;

    logic                take, load_ok;
    logic                lead, trail, samp, shft;
    logic [4:0]          msb, msb_new;
    logic [MAX_WORD-1:0] src, shl;

    assign lead    = sclk_edge & (sclk_s != mode_q[1]);
    assign trail   = sclk_edge & (sclk_s == mode_q[1]);
    assign samp    = mode_q[0] ? trail : lead;
    assign shft    = mode_q[0] ? lead : trail;
    assign msb     = {wl_q, 3'b111};
    assign msb_new = {bus.word_len_i, 3'b111};
    assign src     = full_q ? buf_q : '0;
    assign shl     = {tsr_q[MAX_WORD-2:0], 1'b0};
    assign load_ok = bus.tx_load_i & ~full_q;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        wl_d     = wl_q;
        cnt_d    = cnt_q;
        tsr_d    = tsr_q;
        rsr_d    = rsr_q;
        buf_d    = buf_q;
        full_d   = full_q;
        rx_d     = rx_q;
        rxv_d    = 1'b0;
        und_d    = 1'b0;
        miso_d   = miso_q;
        reload_d = reload_q;
        first_d  = first_q;
        take     = 1'b0;
        // Only arm once the CS chain holds real pin samples at idle.
        arm_d    = arm_q | (flush_q[SYNC_STAGES-1] & cs_s);
        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (arm_q && cs_fall) begin
                    state_d  = XFER;
                    mode_d   = bus.spi_mode_i;
                    wl_d     = bus.word_len_i;
                    cnt_d    = '0;
                    reload_d = 1'b0;
                    take     = 1'b1;
                    tsr_d    = src;
                    first_d  = bus.spi_mode_i[0];
                    if (!bus.spi_mode_i[0]) begin
                        miso_d = src[msb_new];
                    end
                end
            end
            XFER: begin
                if (cs_rise) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    reload_d = 1'b0;
                    first_d  = 1'b0;
                    miso_d   = 1'b0;
                end else begin
                    if (cnt_q == word_bits(wl_q)) begin
                        rx_d     = rsr_q & word_mask(wl_q);
                        rxv_d    = 1'b1;
                        cnt_d    = '0;
                        reload_d = 1'b1;
                    end
                    if (samp) begin
                        rsr_d = {rsr_q[MAX_WORD-2:0], mosi_s};
                        cnt_d = cnt_q + 6'd1;
                    end
                    if (shft) begin
                        if (reload_q) begin
                            take     = 1'b1;
                            tsr_d    = src;
                            miso_d   = src[msb];
                            reload_d = 1'b0;
                        end else if (first_q) begin
                            miso_d  = tsr_q[msb];
                            first_d = 1'b0;
                        end else begin
                            tsr_d  = shl;
                            miso_d = shl[msb];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A same-cycle load lands after the take sees the old content.
        if (take) begin
            full_d = 1'b0;
            und_d  = ~full_q;
        end
        if (load_ok) begin
            buf_d  = bus.tx_data_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge GCLK) begin
        if (RST) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            wl_q     <= '0;
            cnt_q    <= '0;
            tsr_q    <= '0;
            rsr_q    <= '0;
            buf_q    <= '0;
            full_q   <= 1'b0;
            rx_q     <= '0;
            rxv_q    <= 1'b0;
            und_q    <= 1'b0;
            miso_q   <= 1'b0;
            reload_q <= 1'b0;
            first_q  <= 1'b0;
            arm_q    <= 1'b0;
            mosi_q   <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            wl_q     <= wl_d;
            cnt_q    <= cnt_d;
            tsr_q    <= tsr_d;
            rsr_q    <= rsr_d;
            buf_q    <= buf_d;
            full_q   <= full_d;
            rx_q     <= rx_d;
            rxv_q    <= rxv_d;
            und_q    <= und_d;
            miso_q   <= miso_d;
            reload_q <= reload_d;
            first_q  <= first_d;
            arm_q    <= arm_d;
            mosi_q   <= {mosi_q[SYNC_STAGES-2:0], MOSI_i};
            flush_q  <= {flush_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign bus.tx_ready_o = ~full_q;
    assign bus.rx_data_o  = rx_q;
    assign bus.rx_valid_o = rxv_q;
    assign bus.underrun_o = und_q;
    assign bus.busy_o     = (state_q == XFER);
    assign MISO_o         = miso_q;
    assign MISO_oe_o      = (state_q == XFER);

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target (slave) endpoint. It is the counterpart of SPI_master, using the same mode and word-length encodings.
- Oversamples the external SCLK, CS, and MOSI pins in the GCLK domain, then shifts data MSB-first in both directions.
- The parallel side has a single-entry TX holding buffer with a ready/load handshake, and an RX word output with a valid pulse.
- Used as the loopback target in the sim wrapper and as a standalone peripheral-side core.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on the SCLK, CS, and MOSI inputs (minimum 2).

Ports:
- GCLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- spi_mode_i  input  2  {CPOL,CPHA}. Captured at CS assertion.
- word_len_i  input  2  00=8, 01=16, 10=24, 11=32 bits. Captured at CS assertion.
- tx_data_i  input  32  next word to transmit, right-aligned.
- tx_load_i  input  1  writes tx_data_i into the holding buffer when tx_ready_o=1.
- tx_ready_o  output  1  holding buffer empty.
- rx_data_o  output  32  last complete received word, right-aligned, upper bits zero.
- rx_valid_o  output  1  one-cycle pulse when rx_data_o updates.
- underrun_o  output  1  one-cycle pulse when a word starts with an empty holding buffer.
- busy_o  output  1  high while CS is asserted (state XFER).
- SCLK_i  input  1  SPI clock from the master.
- CS_i  input  1  chip select, active-low.
- MOSI_i  input  1  serial data in.
- MISO_o  output  1  serial data out.
- MISO_oe_o  output  1  MISO output enable; equals busy_o.

Behaviour:
- Reset values:
  - tx_ready_o=1.
  - rx_data_o=0, rx_valid_o=0, underrun_o=0.
  - busy_o=0, MISO_o=0, MISO_oe_o=0.
  - FSM=IDLE, bit counter=0, synchronisers loaded with idle levels (CS=1, SCLK=0).
- Synchronisation:
  - SCLK, CS, and MOSI each pass through SYNC_STAGES flops.
  - sclk_d is the synchronised SCLK delayed by one flop; an edge is detected when sclk_s != sclk_d.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Supported SCLK frequency: at most GCLK/8.
- Sample and shift edges:
  - CPHA=0: sample MOSI on the leading edge, update MISO on the trailing edge.
  - CPHA=1: update MISO on the leading edge, sample on the trailing edge.
- FSM IDLE → XFER when synchronised CS falls. On that cycle:
  - Latch mode and word length; N = 8*(word_len+1).
  - Clear the bit counter.
  - Move the holding buffer into the TX shift register. If the buffer is empty, load 0 and pulse underrun_o.
  - CPHA=0: drive bit N-1 on MISO_o immediately.
- XFER, on each sample edge:
  - Shift the synchronised MOSI into the RX shift register LSB.
  - Increment the bit counter.
- Word completion (counter reaches N):
  - On the next GCLK cycle, rx_data_o takes the RX shift register (zero-extended) and rx_valid_o pulses for 1 cycle.
  - Pin-edge to rx_valid_o latency is SYNC_STAGES+2 GCLK cycles.
  - The counter clears and the FSM stays in XFER for back-to-back words.
  - The next word reloads from the holding buffer, with the same underrun rule, at the next shift edge.
  - That shift edge puts MSB N-1 on MISO. CPHA=1 words always start their first bit on a leading edge.
- Holding buffer:
  - A tx_load_i while tx_ready_o=0 is ignored.
  - tx_ready_o rises on the cycle after the buffer moves into the shift register.
  - If a load and a reload happen in the same cycle, the reload takes the old content and the new data is stored; tx_ready_o stays 0.
- Per-CS latching: mode and length changes while busy have no effect until the next CS assertion.
- XFER → IDLE when synchronised CS rises:
  - A partial word is discarded: no rx_valid_o, counter cleared.
  - Any unconsumed holding-buffer data is kept.
  - MISO_oe_o falls on the same cycle as busy_o.
- Reset asserted mid-transfer: all state returns to reset values and the holding buffer is emptied. The block re-arms only on a new CS falling edge observed after RST is released.
- SCLK edges while CS is deasserted are ignored.

Decomposition:
- Shared package (spi_pkg):
  - Mode encodings MODE0..MODE3.
  - word_len encoding and a function returning bit count from word_len.
  - Constant MAX_WORD=32.
- Sub-module spi_sync_edge: a parameterised N-stage synchroniser plus edge detector. Instantiate it once each for SCLK and CS; MOSI uses the synchroniser only.

Test Plan:
1. Mode 0, 8-bit: preload tx 0x3C, master sends 0xA5 at GCLK/8 → MISO bits 0,0,1,1,1,1,0,0; rx_data_o=0x000000A5; a single rx_valid_o pulse; tx_ready_o=1 after the first edge.
2. Mode 3, 32-bit: tx 0xDEADBEEF, master sends 0x12345678 → master receives 0xDEADBEEF; rx_data_o=0x12345678.
3. Mode 1, 16-bit, back-to-back: load 0x1111, then 0x2222 during word 1; master sends 0xAAAA, 0x5555 in one CS → two rx_valid_o pulses with 0xAAAA then 0x5555; MISO carries 0x1111 then 0x2222; no underrun_o.
4. Underrun: CS falls with the buffer empty, mode 2, 24-bit → underrun_o pulses once; MISO sends 0x000000.
5. Abort: CS rises after 5 of 8 bits → no rx_valid_o; busy_o=0; the next full transfer of 0x81 → rx_data_o=0x81.
6. RST asserted for 1 cycle mid-word with the buffer loaded → all outputs at reset values; tx_ready_o=1; the next transfer sends 0x00 and pulses underrun_o.
